fifo_stream_adder: RTL and testbench
====================================

Name: fifo_stream_adder

Overview:
- Compute kernel between the host-to-kernel FIFO (upstream) and the kernel-to-host FIFO (downstream) on the main clock.
- Pops a header word, then N operand words, and reduces the operands with the opcode given in the header.
- Pushes a two-word response: the result, then a status word.
- Replaces the fixed add kernel; the host driver frames jobs as header plus operands.

Parameters:
- RD_LATENCY, 2: rising edges from the edge that registers data_rd=1 to the edge at which data_din is sampled. Legal values 1..4.
- MAX_COUNT, 255: largest operand count accepted. A header count above this is clamped to MAX_COUNT.

Ports:
- clock  in  1  main clock
- reset  in  1  synchronous, active-high reset
- data_empty  in  1  upstream FIFO empty
- data_rd  out  1  upstream FIFO pop strobe, registered
- data_din  in  32  upstream FIFO read data
- data_full  in  1  downstream FIFO full
- data_wr  out  1  downstream FIFO push strobe, registered
- data_dout  out  32  downstream FIFO write data, registered
- busy  out  1  high in every state except IDLE
- job_count  out  16  number of completed jobs, wraps at 0xFFFF

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On reset: data_rd=0, data_wr=0, data_dout=0, busy=0, job_count=0, accumulator=0, state=IDLE. Reset mid-job abandons the job; any upstream words already popped are lost.
- Header word format: [31:24]=opcode, [7:0]=count N.
  - Opcode 0x01 = ADD (sum), 0x02 = XOR, 0x03 = MAX (unsigned).
  - Any other opcode is an error.
- FSM states: IDLE, HDR_WAIT, OP_RD, OP_WAIT, EMIT_RES, EMIT_STAT.
- IDLE: if !data_empty, pulse data_rd for one cycle and go to HDR_WAIT.
- HDR_WAIT: wait RD_LATENCY edges, then latch opcode and N, and clear the accumulator to 0. If N==0, go to EMIT_RES; otherwise go to OP_RD.
- OP_RD: stall while data_empty. Otherwise pulse data_rd and go to OP_WAIT. At most one pop is outstanding at any time.
- OP_WAIT: after RD_LATENCY edges:
  - combine the accumulator with data_din;
  - decrement the remaining count;
  - if the remaining count is now 0, go to EMIT_RES; otherwise go to OP_RD.
- Arithmetic:
  - ADD is 32-bit wrap-around. The overflow flag is set sticky on any carry out of bit 31.
  - XOR is bitwise.
  - MAX keeps the larger unsigned value.
  - For an error opcode, operands are still popped (the stream stays framed) but the accumulator is not updated.
- EMIT_RES: when !data_full is sampled, drive data_wr=1 for exactly one cycle with data_dout=result and go to EMIT_STAT. While full, data_wr stays 0 and the state holds.
  - Result = accumulator.
  - For an error opcode, result = 32'hBAD0_00 followed by the opcode byte.
- EMIT_STAT: same push rule. Status word = {8'hA5, opcode, 6'b0, err, ovf, N[7:0]}. After the push, increment job_count and go to IDLE.
- data_wr and data_rd are never high in the same cycle.
- data_full is checked in the same cycle the push is issued, so the downstream FIFO is never written while full.

Optional Feature:
- Macro: FIFO_STREAM_ADDER_SAT_EN.
- Defined: ADD saturates at 32'hFFFF_FFFF instead of wrapping. The ovf flag is still set when saturation occurs.
- Undefined: ADD wraps modulo 2^32 and sets the sticky ovf flag.
- XOR and MAX are unaffected either way.

Decomposition:
- Package fifo_stream_adder_pkg holds:
  - opcode constants OP_ADD=8'h01, OP_XOR=8'h02, OP_MAX=8'h03;
  - STAT_MAGIC=8'hA5 and ERR_RESULT_HI=24'hBAD000;
  - the FSM state encoding.
- One sub-module, stream_adder_alu: combinational. Inputs: opcode, accumulator, operand. Outputs: next accumulator, carry/saturation flag.

Test Plan:
- Header 32'h0100_0003, operands 1, 2, 3 -> push 32'h0000_0006, then 32'hA501_0003; job_count becomes 1.
- Header 32'h0100_0002, operands 32'hFFFF_FFFF and 32'h0000_0002 -> result 32'h0000_0001 (32'hFFFF_FFFF with SAT_EN); status 32'hA501_0102.
- Header 32'h0200_0002, operands 32'hF0F0_F0F0 and 32'hFFFF_0000 -> result 32'h0F0F_F0F0. Header 32'h0300_0003, operands 5, 9, 7 -> result 32'h0000_0009.
- Header 32'h0700_0001, operand 32'h1234_5678 -> result 32'hBAD0_0007, status 32'hA507_0201; the next job decodes correctly.
- Hold data_full=1 for 10 cycles during EMIT_RES -> no data_wr until it drops, then exactly two pushes. Insert data_empty gaps between operands -> result unchanged.
- Header 32'h0100_0000 -> result 0, status 32'hA501_0000. Assert reset after 2 of 4 operands -> all outputs 0 next cycle, and a new job completes correctly.

Source files
------------

// File: rtl/fifo_stream_adder_pkg.sv
// Shared constants and FSM encoding for the fifo_stream_adder kernel.
package fifo_stream_adder_pkg;

  localparam logic [7:0]  OP_ADD        = 8'h01;
  localparam logic [7:0]  OP_XOR        = 8'h02;
  localparam logic [7:0]  OP_MAX        = 8'h03;

  localparam logic [7:0]  STAT_MAGIC    = 8'hA5;
  localparam logic [23:0] ERR_RESULT_HI = 24'hBAD000;

  typedef enum logic [2:0] {
    StIdle,
    StHdrWait,
    StOpRd,
    StOpWait,
    StEmitRes,
    StEmitStat
  } state_e;

endpackage

// File: rtl/fifo_stream_adder_if.sv
// Upstream (host-to-kernel) and downstream (kernel-to-host) FIFO signals.
// master: the kernel side; slave: the FIFO/host side.
interface fifo_stream_adder_if;
  logic        data_empty;
  logic        data_rd;
  logic [31:0] data_din;
  logic        data_full;
  logic        data_wr;
  logic [31:0] data_dout;

  modport master (
    input  data_empty,
    input  data_din,
    input  data_full,
    output data_rd,
    output data_wr,
    output data_dout
  );

  modport slave (
    output data_empty,
    output data_din,
    output data_full,
    input  data_rd,
    input  data_wr,
    input  data_dout
  );
endinterface

// File: rtl/stream_adder_alu.sv
// Combinational reduction step: folds one operand into the accumulator.
// Build macro FIFO_STREAM_ADDER_SAT_EN: ADD saturates at all-ones instead of wrapping.
module stream_adder_alu
  import fifo_stream_adder_pkg::*;
(
  input  logic [7:0]  opcode_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [31:0] acc_o,
  output logic        flag_o
);

  logic [32:0] sum;
  assign sum = {1'b0, acc_i} + {1'b0, operand_i};

  // Select the next accumulator; unknown opcodes leave it untouched.
  always_comb begin
    acc_o  = acc_i;
    flag_o = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        flag_o = sum[32];
`ifdef FIFO_STREAM_ADDER_SAT_EN
        acc_o  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
        acc_o  = sum[31:0];
`endif
      end
      OP_XOR:  acc_o = acc_i ^ operand_i;
      OP_MAX:  acc_o = (operand_i > acc_i) ? operand_i : acc_i;
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/fifo_stream_adder.sv
// Stream kernel: pops a header then N operands, reduces them with the header
// opcode, and pushes a result word followed by a status word.
// Build macro FIFO_STREAM_ADDER_SAT_EN selects saturating ADD.
module fifo_stream_adder
  import fifo_stream_adder_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned MAX_COUNT  = 255
) (
  input  logic                clock,
  input  logic                reset,
  fifo_stream_adder_if.master bus,
  output logic                busy,
  output logic [15:0]         job_count
);

  localparam logic [2:0] LatLast = 3'(RD_LATENCY);
  localparam logic [7:0] CntMax  = 8'(MAX_COUNT);

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  lat_q, lat_d;
  logic [15:0] job_q, job_d;

  logic [31:0] alu_acc;
  logic        alu_flag;
  logic        op_err;
  logic [7:0]  hdr_cnt;

  assign op_err  = !(op_q inside {OP_ADD, OP_XOR, OP_MAX});
  assign hdr_cnt = (32'(bus.data_din[7:0]) > MAX_COUNT) ? CntMax : bus.data_din[7:0];

  stream_adder_alu u_alu (
    .opcode_i  (op_q),
    .acc_i     (acc_q),
    .operand_i (bus.data_din),
    .acc_o     (alu_acc),
    .flag_o    (alu_flag)
  );

  // Next-state and strobe generation; lat_q counts edges since the pop was registered.
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    dout_d  = dout_q;
    acc_d   = acc_q;
    op_d    = op_q;
    n_d     = n_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    lat_d   = lat_q;
    job_d   = job_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.data_empty) begin
          rd_d    = 1'b1;
          lat_d   = 3'd1;
          state_d = StHdrWait;
        end
      end
      StHdrWait: begin
        if (lat_q == LatLast) begin
          op_d    = bus.data_din[31:24];
          n_d     = hdr_cnt;
          rem_d   = hdr_cnt;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (hdr_cnt == 8'd0) ? StEmitRes : StOpRd;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StOpRd: begin
        if (!bus.data_empty) begin
          rd_d    = 1'b1;
          lat_d   = 3'd1;
          state_d = StOpWait;
        end
      end
      StOpWait: begin
        if (lat_q == LatLast) begin
          acc_d   = alu_acc;
          ovf_d   = ovf_q | alu_flag;
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? StEmitRes : StOpRd;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StEmitRes: begin
        if (!bus.data_full) begin
          wr_d    = 1'b1;
          dout_d  = op_err ? {ERR_RESULT_HI, op_q} : acc_q;
          state_d = StEmitStat;
        end
      end
      StEmitStat: begin
        if (!bus.data_full) begin
          wr_d    = 1'b1;
          dout_d  = {STAT_MAGIC, op_q, 6'b0, op_err, ovf_q, n_q};
          job_d   = job_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      lat_q   <= '0;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      lat_q   <= lat_d;
      job_q   <= job_d;
    end
  end

  assign bus.data_rd   = rd_q;
  assign bus.data_wr   = wr_q;
  assign bus.data_dout = dout_q;
  assign busy          = (state_q != StIdle);
  assign job_count     = job_q;

endmodule

// File: tb/tb_fifo_stream_adder.sv
// Bench for fifo_stream_adder: fixed vectors, hand-written corner sequences and
// random jobs checked against an arithmetic reference model.
module tb_fifo_stream_adder;

  localparam int RdLat = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [15:0] job_count;

  fifo_stream_adder_if bus ();

  fifo_stream_adder #(
    .RD_LATENCY (RdLat),
    .MAX_COUNT  (255)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]       hdr;
    logic [3:0][31:0]  ops;
    logic [31:0]       res;
    logic [31:0]       stat;
  } vec_t;

`ifdef FIFO_STREAM_ADDER_SAT_EN
  localparam logic [31:0] AddOvfRes = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] AddOvfRes = 32'h0000_0001;
`endif

  int          n_vec = 0;
  int          n_miss = 0;
  int          n_pops = 0;
  logic [31:0] up_q[$];
  logic [31:0] dn_q[$];
  logic [31:0] job_ops[8];
  bit          full_force = 1'b0;
  bit          rnd_full = 1'b0;
  bit          gap_en = 1'b0;
  logic [15:0] model_jobs = '0;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] hdr, input logic [31:0] o0, input logic [31:0] o1,
                               input logic [31:0] o2, input logic [31:0] o3,
                               input logic [31:0] res, input logic [31:0] stat);
    vec_t v;
    v.hdr    = hdr;
    v.ops[0] = o0;
    v.ops[1] = o1;
    v.ops[2] = o2;
    v.ops[3] = o3;
    v.res    = res;
    v.stat   = stat;
    return v;
  endfunction

  // Reference: reduce the whole operand list at once with plain arithmetic.
  function automatic void model_job(input logic [31:0] hdr, output logic [31:0] res,
                                    output logic [31:0] stat);
    logic [7:0]      op;
    int              n;
    longint unsigned total;
    logic [31:0]     x;
    logic [31:0]     mx;
    bit              err;
    bit              ovf;
    op    = hdr[31:24];
    n     = int'(hdr[7:0]);
    total = 0;
    x     = '0;
    mx    = '0;
    for (int i = 0; i < n; i++) begin
      total += longint'(job_ops[i]);
      x ^= job_ops[i];
      if (job_ops[i] > mx) mx = job_ops[i];
    end
    err = !(op == 8'h01 || op == 8'h02 || op == 8'h03);
    ovf = 1'b0;
    case (op)
      8'h01: begin
        ovf = (total > 64'hFFFF_FFFF);
`ifdef FIFO_STREAM_ADDER_SAT_EN
        res = ovf ? 32'hFFFF_FFFF : total[31:0];
`else
        res = total[31:0];
`endif
      end
      8'h02:   res = x;
      8'h03:   res = mx;
      default: res = {24'hBAD000, op};
    endcase
    stat = {8'hA5, op, 6'b0, err, ovf, hdr[7:0]};
  endfunction

  // Upstream FIFO with RdLat read latency (garbage outside the valid edge) and
  // downstream FIFO capture plus protocol checks, all on the falling edge.
  initial begin : fifo_model
    logic [31:0] pend_word;
    bit          pend_vld;
    int          pend_dly;
    pend_word      = '0;
    pend_vld       = 1'b0;
    pend_dly       = 0;
    bus.data_empty = 1'b1;
    bus.data_full  = 1'b0;
    bus.data_din   = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        up_q.delete();
        dn_q.delete();
        pend_vld = 1'b0;
      end else begin
        if (bus.data_rd || bus.data_wr)
          check("rd_wr_exclusive", 32'(bus.data_rd & bus.data_wr), 32'd0);
        if (bus.data_wr) begin
          check("push_when_full", 32'(bus.data_full), 32'd0);
          dn_q.push_back(bus.data_dout);
        end
        bus.data_din = $urandom;
        if (bus.data_rd) begin
          check("pop_when_empty", 32'(bus.data_empty), 32'd0);
          if (up_q.size() != 0) begin
            pend_word = up_q.pop_front();
            pend_vld  = 1'b1;
            pend_dly  = RdLat - 1;
            n_pops++;
          end
        end
        if (pend_vld) begin
          if (pend_dly == 0) begin
            bus.data_din = pend_word;
            pend_vld     = 1'b0;
          end else begin
            pend_dly--;
          end
        end
      end
      bus.data_empty = (up_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
      bus.data_full  = full_force || (rnd_full && $urandom_range(0, 3) == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_words(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (dn_q.size() < n && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    ok = (dn_q.size() >= n);
    if (!ok) check("timeout_words", 32'(dn_q.size()), 32'(n));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".rd"},        32'(bus.data_rd), 32'd0);
    check({tag, ".wr"},        32'(bus.data_wr), 32'd0);
    check({tag, ".dout"},      bus.data_dout,    32'd0);
    check({tag, ".busy"},      32'(busy),        32'd0);
    check({tag, ".job_count"}, 32'(job_count),   32'd0);
  endtask

  task automatic load_job(input logic [31:0] hdr);
    up_q.push_back(hdr);
    for (int i = 0; i < int'(hdr[7:0]); i++) up_q.push_back(job_ops[i]);
  endtask

  task automatic apply_job(input string tag, input logic [31:0] hdr,
                           input logic [31:0] exp_res, input logic [31:0] exp_stat);
    bit ok;
    load_job(hdr);
    wait_words(2, ok);
    if (ok) begin
      check({tag, ".result"}, dn_q.pop_front(), exp_res);
      check({tag, ".status"}, dn_q.pop_front(), exp_stat);
      model_jobs++;
      check({tag, ".job_count"}, 32'(job_count), 32'(model_jobs));
      check({tag, ".busy_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    for (int k = 0; k < 4; k++) job_ops[k] = v.ops[k];
    apply_job(tag, v.hdr, v.res, v.stat);
  endtask

  initial begin : main
    bit          ok;
    int          pops0;
    logic [31:0] hdr;
    logic [31:0] r;
    logic [31:0] s;
    logic [7:0]  op;
    int          n;

    vecs[0] = mkv(32'h0100_0003, 32'd1, 32'd2, 32'd3, 32'd0, 32'h0000_0006, 32'hA501_0003);
    vecs[1] = mkv(32'h0100_0002, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, AddOvfRes, 32'hA501_0102);
    vecs[2] = mkv(32'h0200_0002, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 32'd0,
                  32'h0F0F_F0F0, 32'hA502_0002);
    vecs[3] = mkv(32'h0300_0003, 32'd5, 32'd9, 32'd7, 32'd0, 32'h0000_0009, 32'hA503_0003);
    vecs[4] = mkv(32'h0700_0001, 32'h1234_5678, 32'd0, 32'd0, 32'd0,
                  32'hBAD0_0007, 32'hA507_0201);
    vecs[5] = mkv(32'h0100_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0000, 32'hA501_0000);
    vecs[6] = mkv(32'h0300_0002, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,
                  32'hFFFF_FFFF, 32'hA503_0002);

    reset = 1'b1;
    tick(2);
    check_quiet("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Downstream full held while the result is ready.
    full_force = 1'b1;
    job_ops[0] = 32'd1;
    job_ops[1] = 32'd2;
    job_ops[2] = 32'd3;
    load_job(32'h0100_0003);
    tick(40);
    check("full_hold.no_push", 32'(dn_q.size()), 32'd0);
    check("full_hold.busy", 32'(busy), 32'd1);
    full_force = 1'b0;
    wait_words(2, ok);
    if (ok) begin
      check("full_hold.result", dn_q.pop_front(), 32'h0000_0006);
      check("full_hold.status", dn_q.pop_front(), 32'hA501_0003);
      model_jobs++;
      check("full_hold.job_count", 32'(job_count), 32'(model_jobs));
    end
    tick(5);
    check("full_hold.extra_push", 32'(dn_q.size()), 32'd0);

    // Empty gaps between operands.
    gap_en = 1'b1;
    apply_vec("gap0", vecs[0]);
    apply_vec("gap3", vecs[3]);
    gap_en = 1'b0;

    // Reset after two of four operands.
    pops0      = n_pops;
    job_ops[0] = 32'd10;
    job_ops[1] = 32'd20;
    up_q.push_back(32'h0100_0004);
    up_q.push_back(job_ops[0]);
    up_q.push_back(job_ops[1]);
    tick(25);
    check("mid_reset.pops", 32'(n_pops - pops0), 32'd3);
    check("mid_reset.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    check_quiet("mid_reset");
    reset      = 1'b0;
    model_jobs = '0;
    apply_vec("after_reset", vecs[0]);

    // Random jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      rnd_full = 1'($urandom_range(0, 1));
      gap_en   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 4:    op = 8'h01;
        1:       op = 8'h02;
        2:       op = 8'h03;
        default: op = 8'($urandom_range(4, 255));
      endcase
      n   = $urandom_range(0, 6);
      hdr = {op, 16'($urandom), 8'(n)};
      for (int k = 0; k < n; k++)
        job_ops[k] = $urandom_range(0, 1) ? (32'hF000_0000 | $urandom) : 32'($urandom_range(0, 1000));
      model_job(hdr, r, s);
      apply_job($sformatf("rand%0d", j), hdr, r, s);
    end
    rnd_full = 1'b0;
    gap_en   = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
